key_debounce: RTL and testbench



---
 rtl/key_debounce.sv | 151 +++++++++++++++
 tb/tb_key_debounce.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop sync, per-key stability counter, registered level/press/release.
// Define KEY_DEBOUNCE_REPEAT_EN to build auto-repeat press pulses while a key is held.
module key_debounce #(
  parameter int unsigned NKEYS           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [NKEYS-1:0] KEY,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release
);

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } key_state_e;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NKEYS-1:0] s1;
  logic [NKEYS-1:0] s2;
  logic [NKEYS-1:0] samp;

  key_state_e       state_q [NKEYS];
  key_state_e       state_d [NKEYS];
  logic [CNT_W-1:0] cnt_q   [NKEYS];
  logic [CNT_W-1:0] cnt_d   [NKEYS];

  logic [NKEYS-1:0] accept_press;
  logic [NKEYS-1:0] accept_release;
  logic [NKEYS-1:0] press_d;
  logic [NKEYS-1:0] press_q;
  logic [NKEYS-1:0] release_d;
  logic [NKEYS-1:0] release_q;

  // Synchroniser resets to all ones so an idle (released) key reads as such.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= KEY;
      s2 <= s1;
    end
  end

  assign samp = ~s2;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned k = 0; k < NKEYS; k++) begin
        state_q[k] <= RELEASED;
        cnt_q[k]   <= '0;
      end
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NKEYS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Any sample matching the accepted level restarts the stability run.
  always_comb begin
    accept_press   = '0;
    accept_release = '0;
    for (int unsigned k = 0; k < NKEYS; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = '0;
      if (samp[k] != state_q[k]) begin
        if (cnt_q[k] == DB_LAST) begin
          state_d[k]        = samp[k] ? PRESSED : RELEASED;
          accept_press[k]   = samp[k];
          accept_release[k] = ~samp[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rcnt_q [NKEYS];
  logic [CNT_W-1:0] rcnt_d [NKEYS];
  logic [NKEYS-1:0] rphase_q;
  logic [NKEYS-1:0] rphase_d;
  logic [NKEYS-1:0] repeat_hit;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned k = 0; k < NKEYS; k++) begin
        rcnt_q[k] <= '0;
      end
      rphase_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NKEYS; k++) begin
        rcnt_q[k] <= rcnt_d[k];
      end
      rphase_q <= rphase_d;
    end
  end

  // rphase selects the initial delay versus the steady repeat period; the
  // counter sits at zero while released, so the accepted press clears it.
  always_comb begin
    repeat_hit = '0;
    rphase_d   = '0;
    for (int unsigned k = 0; k < NKEYS; k++) begin
      rcnt_d[k] = '0;
      if ((state_q[k] == PRESSED) && !accept_release[k]) begin
        if (rcnt_q[k] == (rphase_q[k] ? RPT_NEXT : RPT_FIRST)) begin
          repeat_hit[k] = 1'b1;
          rphase_d[k]   = 1'b1;
        end else begin
          rcnt_d[k]   = rcnt_q[k] + 1'b1;
          rphase_d[k] = rphase_q[k];
        end
      end
    end
  end

  assign press_d = accept_press | repeat_hit;
`else
  assign press_d = accept_press;
`endif

  assign release_d = accept_release;

  always_comb begin
    key_level = '0;
    for (int unsigned k = 0; k < NKEYS; k++) begin
      key_level[k] = (state_q[k] == PRESSED);
    end
  end

  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_key_debounce;

  localparam int NK = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int P  = DB + 2;  // edges from a stable KEY change to its pulse

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  key   = 4'hF;
  logic [3:0]  lvl;
  logic [3:0]  prs;
  logic [3:0]  rel;

  logic [11:0] exp_q[$];
  logic [11:0] want;
  int          n_pass  = 0;
  int          n_total = 0;

  key_debounce #(
    .NKEYS(NK),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(8),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .CLOCK_50(clk),
    .RESET_N(rst_n),
    .KEY(key),
    .key_level(lvl),
    .key_press(prs),
    .key_release(rel)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [3:0] l, input logic [3:0] p, input logic [3:0] r);
    exp_q.push_back({l, p, r});
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    for (int e = 1; e <= 3; e++) push(4'h0, 4'h0, 4'h0);
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_total++;
      if ({lvl, prs, rel} !== want)
        $display("FAIL reset e=%0d: got lvl/press/rel=%b_%b_%b want %b", e, lvl, prs, rel, want);
      else n_pass++;
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 4; e++) push(4'h0, 4'h0, 4'h0);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_total++;
      if ({lvl, prs, rel} !== want)
        $display("FAIL idle e=%0d: got lvl/press/rel=%b_%b_%b want %b", e, lvl, prs, rel, want);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    for (int e = 1; e <= 9; e++)
      push((e >= P) ? 4'b0001 : 4'b0000, (e == P) ? 4'b0001 : 4'b0000, 4'b0000);
    for (int e = 1; e <= 9; e++) begin
      key = 4'b1110;
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_total++;
      if ({lvl, prs, rel} !== want)
        $display("FAIL clean_press e=%0d: got lvl/press/rel=%b_%b_%b want %b", e, lvl, prs, rel, want);
      else n_pass++;
    end
  endtask

  task automatic test_release();
    for (int e = 1; e <= 8; e++)
      push((e < P) ? 4'b0001 : 4'b0000, 4'b0000, (e == P) ? 4'b0001 : 4'b0000);
    for (int e = 1; e <= 8; e++) begin
      key = 4'hF;
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_total++;
      if ({lvl, prs, rel} !== want)
        $display("FAIL release e=%0d: got lvl/press/rel=%b_%b_%b want %b", e, lvl, prs, rel, want);
      else n_pass++;
    end
  endtask

  // Low 3, high 3, low 8, then released: only the final low run is accepted.
  task automatic test_bounce();
    for (int e = 1; e <= 22; e++)
      push((e >= 12 && e < 20) ? 4'b0001 : 4'b0000,
           (e == 12) ? 4'b0001 : 4'b0000,
           (e == 20) ? 4'b0001 : 4'b0000);
    for (int e = 1; e <= 22; e++) begin
      key = (e <= 3 || (e >= 7 && e <= 14)) ? 4'b1110 : 4'hF;
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_total++;
      if ({lvl, prs, rel} !== want)
        $display("FAIL bounce e=%0d: got lvl/press/rel=%b_%b_%b want %b", e, lvl, prs, rel, want);
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    for (int e = 1; e <= 16; e++)
      push((e >= P && e < 14) ? 4'hF : 4'h0,
           (e == P) ? 4'hF : 4'h0,
           (e == 14) ? 4'hF : 4'h0);
    for (int e = 1; e <= 16; e++) begin
      key = (e <= 8) ? 4'b0000 : 4'hF;
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_total++;
      if ({lvl, prs, rel} !== want)
        $display("FAIL simultaneous e=%0d: got lvl/press/rel=%b_%b_%b want %b", e, lvl, prs, rel, want);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_count();
    // Key 0 accepted at edge 6, key 1 starts counting from edge 7 and reaches 3 at edge 11.
    for (int e = 1; e <= 11; e++)
      push((e >= P) ? 4'b0001 : 4'b0000, (e == P) ? 4'b0001 : 4'b0000, 4'b0000);
    for (int e = 1; e <= 11; e++) begin
      key = (e <= 6) ? 4'b1110 : 4'b1100;
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_total++;
      if ({lvl, prs, rel} !== want)
        $display("FAIL mid_count_pre e=%0d: got lvl/press/rel=%b_%b_%b want %b", e, lvl, prs, rel, want);
      else n_pass++;
    end
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({lvl, prs, rel} !== 12'h000)
      $display("FAIL async_reset: got lvl/press/rel=%b_%b_%b want 000000000000", lvl, prs, rel);
    else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Both held keys need a full fresh run after reset, then both release together.
    for (int e = 1; e <= 16; e++)
      push((e >= P && e < 14) ? 4'b0011 : 4'b0000,
           (e == P) ? 4'b0011 : 4'b0000,
           (e == 14) ? 4'b0011 : 4'b0000);
    for (int e = 1; e <= 16; e++) begin
      key = (e <= 8) ? 4'b1100 : 4'hF;
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_total++;
      if ({lvl, prs, rel} !== want)
        $display("FAIL mid_count_post e=%0d: got lvl/press/rel=%b_%b_%b want %b", e, lvl, prs, rel, want);
      else n_pass++;
    end
  endtask

  // Long hold on key 2: repeat pulses when built with auto-repeat, a single press otherwise.
  task automatic test_hold();
    logic rpt;
    for (int e = 1; e <= 32; e++) begin
`ifdef KEY_DEBOUNCE_REPEAT_EN
      rpt = (e >= P + RD) && (e < 29) && (((e - (P + RD)) % RP) == 0);
`else
      rpt = 1'b0;
`endif
      push((e >= P && e < 29) ? 4'b0100 : 4'b0000,
           ((e == P) || rpt) ? 4'b0100 : 4'b0000,
           (e == 29) ? 4'b0100 : 4'b0000);
    end
    for (int e = 1; e <= 32; e++) begin
      key = (e <= 23) ? 4'b1011 : 4'hF;
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_total++;
      if ({lvl, prs, rel} !== want)
        $display("FAIL hold e=%0d: got lvl/press/rel=%b_%b_%b want %b", e, lvl, prs, rel, want);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    test_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got unfinished want finished");
    $fatal(1);
  end

endmodule
